// File: rtl/cpu_ctrl_pkg.sv
// Shared types and opcode map for the multi-cycle CPU control sequencer.
// Instruction layout: opcode[18:13] rd[12:8] rs[7:3] imm[2:0].
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LD,
        CL_ST,
        CL_BR,
        CL_NOP,
        CL_HALT,
        CL_RSV
    } op_class_t;

    typedef enum logic [1:0] {
        BC_NONE,
        BC_EQ,
        BC_NE,
        BC_ALWAYS
    } br_cond_t;

    localparam logic [5:0] OP_ALU_LAST = 6'h1F;
    localparam logic [5:0] OP_LD       = 6'h20;
    localparam logic [5:0] OP_ST       = 6'h21;
    localparam logic [5:0] OP_BEQ      = 6'h22;
    localparam logic [5:0] OP_BNE      = 6'h23;
    localparam logic [5:0] OP_JMP      = 6'h24;
    localparam logic [5:0] OP_NOP      = 6'h3E;
    localparam logic [5:0] OP_HALT     = 6'h3F;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;

    // Anything not explicitly mapped falls into the reserved class.
    function automatic op_class_t op_class(input logic [5:0] op);
        op_class_t cls;
        if (op <= OP_ALU_LAST) begin
            cls = CL_ALU;
        end else begin
            case (op)
                OP_LD:                  cls = CL_LD;
                OP_ST:                  cls = CL_ST;
                OP_BEQ, OP_BNE, OP_JMP: cls = CL_BR;
                OP_NOP:                 cls = CL_NOP;
                OP_HALT:                cls = CL_HALT;
                default:                cls = CL_RSV;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decode: instruction class and branch-condition select.
module cpu_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_t  o_class,
    output br_cond_t   o_cond
);

    always_comb begin
        o_class = op_class(i_opcode);
        o_cond  = BC_NONE;
        case (i_opcode)
            OP_BEQ:  o_cond = BC_EQ;
            OP_BNE:  o_cond = BC_NE;
            OP_JMP:  o_cond = BC_ALWAYS;
            default: o_cond = BC_NONE;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control FSM: latches the instruction, sequences
// fetch/decode/execute/memory/writeback and drives every datapath strobe.
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int XLEN        = 19,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instructions,
    input  logic [7:0]      FLAG,
    input  logic            mem_ack,
    output logic [5:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs,
    output logic [2:0]      imm,
    output logic            aluen,
    output logic            memread,
    output logic            memwrite,
    output logic            regwrite,
    output logic            branch,
    output logic            pc_en,
    output logic            halted,
    output logic            mem_err,
    output logic            illegal,
    output logic [15:0]     instret,
    output logic [2:0]      state
);

    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t          r_state;
    logic [XLEN-1:0] r_ir;
    logic [7:0]      r_wait;
    logic            r_halted;
    logic            r_mem_err;
    logic [15:0]     r_instret;

    op_class_t w_class;
    br_cond_t  w_cond;
    logic      w_taken;
    logic      w_retire;
    logic      w_unused_flags;

    assign opcode = r_ir[XLEN-1 -: 6];
    assign rd     = r_ir[XLEN-7 -: 5];
    assign rs     = r_ir[XLEN-12 -: 5];
    assign imm    = r_ir[2:0];

    assign w_unused_flags = ^{FLAG[7:3], FLAG[FLAG_NEG], FLAG[FLAG_CARRY]};

    cpu_decode u_decode (
        .i_opcode (opcode),
        .o_class  (w_class),
        .o_cond   (w_cond)
    );

    always_comb begin
        case (w_cond)
            BC_EQ:     w_taken = FLAG[FLAG_ZERO];
            BC_NE:     w_taken = ~FLAG[FLAG_ZERO];
            BC_ALWAYS: w_taken = 1'b1;
            default:   w_taken = 1'b0;
        endcase
    end

    // The retire cycle is the single cycle of each instruction in which the PC advances.
    always_comb begin
        case (r_state)
            ST_DECODE: w_retire = (w_class == CL_NOP) || (w_class == CL_RSV);
            ST_EXEC:   w_retire = (w_class == CL_BR);
            ST_MEM:    w_retire = (w_class == CL_ST) && mem_ack;
            ST_WB:     w_retire = 1'b1;
            default:   w_retire = 1'b0;
        endcase
    end

    always_comb begin
        aluen    = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        branch   = 1'b0;
        pc_en    = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            aluen    = (r_state == ST_EXEC) &&
                       ((w_class == CL_ALU) || (w_class == CL_LD) || (w_class == CL_ST));
            memread  = (r_state == ST_MEM) && (w_class == CL_LD);
            memwrite = (r_state == ST_MEM) && (w_class == CL_ST);
            regwrite = (r_state == ST_WB);
            branch   = (r_state == ST_EXEC) && (w_class == CL_BR) && w_taken;
            pc_en    = w_retire;
            illegal  = (r_state == ST_DECODE) && (w_class == CL_RSV);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_wait    <= '0;
            r_halted  <= 1'b0;
            r_mem_err <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + 16'd1;
            end
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= instructions;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (w_class)
                        CL_NOP, CL_RSV: r_state <= ST_FETCH;
                        CL_HALT: begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                        default: r_state <= ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    case (w_class)
                        CL_ALU: r_state <= ST_WB;
                        CL_LD, CL_ST: begin
                            r_state <= ST_MEM;
                            r_wait  <= '0;
                        end
                        default: r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    // An ack arriving in the timeout cycle still completes the access.
                    if (mem_ack) begin
                        r_state <= (w_class == CL_LD) ? ST_WB : ST_FETCH;
                    end else if (r_wait == LP_WAIT_LAST) begin
                        r_state   <= ST_HALT;
                        r_halted  <= 1'b1;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign halted  = r_halted;
    assign mem_err = r_mem_err;
    assign instret = r_instret;
    assign state   = r_state;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Scoreboarded bench for cpu_control_sequencer: per-instruction expectations
// from a cycle-count model, checked by an independent monitor.
module tb_cpu_control_sequencer;

  localparam int MEM_TIMEOUT = 15;
  localparam int NEVER = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] instructions = '0;
  logic [7:0]  FLAG = '0;
  logic        mem_ack = 1'b0;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [2:0]  imm;
  logic        aluen, memread, memwrite, regwrite, branch, pc_en;
  logic        halted, mem_err, illegal;
  logic [15:0] instret;
  logic [2:0]  state;

  cpu_control_sequencer #(.XLEN(19), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .instructions(instructions), .FLAG(FLAG), .mem_ack(mem_ack),
    .opcode(opcode), .rd(rd), .rs(rs), .imm(imm),
    .aluen(aluen), .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
    .branch(branch), .pc_en(pc_en), .halted(halted), .mem_err(mem_err),
    .illegal(illegal), .instret(instret), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // kind: 0 = retires, 1 = HALT opcode, 2 = memory timeout
  typedef struct {
    int          kind;
    logic [18:0] ir;
    int          cyc;
    int          alu;
    int          mrd;
    int          mwr;
    int          rgw;
    int          ill;
    int          br;
    logic [15:0] instret;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model_instret = '0;
  int          ack_wait = NEVER;

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // reference model: cost and observable effects of one instruction
  function automatic exp_t predict(input logic [18:0] ir, input logic [7:0] flag, input int w,
                                   input logic [15:0] cnt);
    exp_t e;
    int   op;
    op = int'(ir[18:13]);
    e.kind = 0; e.ir = ir; e.cyc = 0; e.alu = 0; e.mrd = 0; e.mwr = 0;
    e.rgw = 0; e.ill = 0; e.br = 0; e.instret = cnt;
    if (op < 32) begin
      e.cyc = 4; e.alu = 1; e.rgw = 1;
    end else if (op == 32 || op == 33) begin
      e.alu = 1;
      if (w >= MEM_TIMEOUT) begin
        e.kind = 2;
        e.cyc = 3 + MEM_TIMEOUT;
        if (op == 32) e.mrd = MEM_TIMEOUT; else e.mwr = MEM_TIMEOUT;
      end else if (op == 32) begin
        e.cyc = 5 + w; e.mrd = w + 1; e.rgw = 1;
      end else begin
        e.cyc = 4 + w; e.mwr = w + 1;
      end
    end else if (op <= 36) begin
      e.cyc = 3;
      e.br = (op == 36 || (op == 34 && flag[0]) || (op == 35 && !flag[0])) ? 1 : 0;
    end else if (op == 63) begin
      e.kind = 1; e.cyc = 2;
    end else begin
      e.cyc = 2;
      e.ill = (op != 62) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic score(input int kind, input int cyc, input int alu, input int mrd, input int mwr,
                       input int rgw, input int ill, input int br);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: kind %0d observed, no expected entry queued", kind);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 32'(kind), 32'(e.kind));
    check("ir_fields", 32'({opcode, rd, rs, imm}), 32'(e.ir));
    check("cycles", 32'(cyc), 32'(e.cyc));
    check("aluen_cycles", 32'(alu), 32'(e.alu));
    check("memread_cycles", 32'(mrd), 32'(e.mrd));
    check("memwrite_cycles", 32'(mwr), 32'(e.mwr));
    check("regwrite_cycles", 32'(rgw), 32'(e.rgw));
    check("illegal_pulses", 32'(ill), 32'(e.ill));
    check("branch", 32'(br), 32'(e.br));
    check("instret", 32'(instret), 32'(e.instret));
  endtask

  // data memory responder: ack after ack_wait stalled cycles
  initial begin
    int mcnt;
    mcnt = 0;
    forever begin
      @(negedge clk);
      if (memread || memwrite) begin
        mem_ack = (mcnt == ack_wait);
        mcnt++;
      end else begin
        mem_ack = 1'b0;
        mcnt = 0;
      end
    end
  end

  // monitor
  initial begin
    int cyc, alu, mrd, mwr, rgw, ill, br;
    bit halt_seen;
    cyc = 0; alu = 0; mrd = 0; mwr = 0; rgw = 0; ill = 0; br = 0; halt_seen = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        cyc = 0; alu = 0; mrd = 0; mwr = 0; rgw = 0; ill = 0; br = 0; halt_seen = 0;
      end else if (halted) begin
        if (!halt_seen) begin
          halt_seen = 1;
          score(mem_err ? 2 : 1, cyc, alu, mrd, mwr, rgw, ill, br);
        end
        check("halt_quiet", 32'({aluen, memread, memwrite, regwrite, branch, pc_en, illegal}), 32'd0);
      end else begin
        cyc++;
        alu += int'(aluen); mrd += int'(memread); mwr += int'(memwrite);
        rgw += int'(regwrite); ill += int'(illegal); br += int'(branch);
        if (memread && memwrite) check("mem_exclusive", 32'd1, 32'd0);
        if (pc_en) begin
          score(0, cyc, alu, mrd, mwr, rgw, ill, br);
          cyc = 0; alu = 0; mrd = 0; mwr = 0; rgw = 0; ill = 0; br = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [5:0] op, input logic [7:0] flag, input int w);
    logic [18:0] ir;
    exp_t        e;
    int          n;
    ir = {op, 5'($urandom), 5'($urandom), 3'($urandom)};
    e = predict(ir, flag, w, model_instret);
    if (e.kind == 0) model_instret++;
    exp_q.push_back(e);
    instructions = ir;
    FLAG = flag;
    ack_wait = w;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(pc_en || halted) && n < 64);
    if (!(pc_en || halted)) begin
      n_fail++;
      $display("FAIL completion_wait: no retire or halt within %0d cycles for opcode 0x%0h", n, op);
      report();
      $finish;
    end
    #1;
  endtask

  task automatic reset_checks();
    check("rst_state", 32'(state), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_ir", 32'({opcode, rd, rs, imm}), 32'd0);
    check("rst_strobes", 32'({aluen, memread, memwrite, regwrite, branch, pc_en, illegal}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_instret = '0;
    #1;
    reset_checks();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
    $finish;
  end

  // stimulus
  initial begin
    logic [18:0] ir;
    int          sel;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("strobes_in_reset", 32'({aluen, memread, memwrite, regwrite, branch, pc_en, illegal}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset_checks();

    issue(6'h05, 8'h00, NEVER);
    issue(6'h20, 8'h00, 3);
    issue(6'h21, 8'h00, 0);
    issue(6'h22, 8'h01, NEVER);
    issue(6'h22, 8'h00, NEVER);
    issue(6'h23, 8'h01, NEVER);
    issue(6'h23, 8'h00, NEVER);
    issue(6'h24, 8'hF6, NEVER);
    issue(6'h20, 8'h00, MEM_TIMEOUT - 1);
    issue(6'h21, 8'h00, MEM_TIMEOUT - 1);
    issue(6'h3E, 8'h00, NEVER);
    issue(6'h30, 8'h00, NEVER);
    issue(6'h25, 8'h00, NEVER);
    issue(6'h3D, 8'h00, NEVER);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: issue(6'($urandom_range(0, 31)), 8'($urandom), NEVER);
        1: issue(6'h20, 8'($urandom), $urandom_range(0, 5));
        2: issue(6'h21, 8'($urandom), $urandom_range(0, 5));
        3: issue(6'($urandom_range(34, 36)), 8'($urandom), NEVER);
        4: issue(6'h3E, 8'($urandom), NEVER);
        default: issue(6'($urandom_range(37, 61)), 8'($urandom), NEVER);
      endcase
    end

    issue(6'h20, 8'h00, NEVER);
    repeat (3) @(negedge clk);
    do_reset();

    issue(6'h11, 8'h00, NEVER);
    issue(6'h21, 8'h00, NEVER);
    repeat (3) @(negedge clk);
    do_reset();

    issue(6'h05, 8'h00, NEVER);
    issue(6'h3F, 8'h00, NEVER);
    repeat (3) @(negedge clk);
    do_reset();

    issue(6'h07, 8'h00, NEVER);
    ir = {6'h20, 13'($urandom)};
    instructions = ir;
    ack_wait = NEVER;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_in_mem_state", 32'(state), 32'd3);
    check("abort_strobes", 32'({aluen, memread, memwrite, regwrite, branch, pc_en, illegal}), 32'd0);
    check("abort_no_retire", 32'(instret), 32'(model_instret));
    @(negedge clk);
    reset = 1'b0;
    model_instret = '0;
    #1;
    reset_checks();

    issue(6'h1F, 8'h00, NEVER);
    issue(6'h20, 8'h00, 0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    report();
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Multi-cycle control FSM for the 19-bit CPU core. It latches the fetched instruction, decodes the 6-bit opcode, and sequences the existing ALU, register file, data memory and program counter through fetch/decode/execute/memory/writeback. It produces every datapath strobe (`aluen`, `memread`, `memwrite`, `regwrite`, `branch`, `pc_en`) and replaces the free-running single-cycle control in the core top.

## Interface
Parameters:
- `XLEN`, 19: instruction width.
- `MEM_TIMEOUT`, 15: maximum MEM-state cycles without `mem_ack` before a fatal halt; legal range 1–255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `instructions`  in  19  instruction word from instruction memory at the current PC.
- `FLAG`  in  8  ALU flags; bit0 = zero, bit1 = carry, bit2 = negative.
- `mem_ack`  in  1  data memory completed the current read or write.
- `opcode`, `rd`, `rs`, `imm`  out  6/5/5/3  fields of the latched instruction register (IR).
- `aluen`, `memread`, `memwrite`, `regwrite`, `branch`, `pc_en`  out  1 each  datapath strobes.
- `halted`  out  1  sticky; set by HALT or a memory timeout.
- `mem_err`  out  1  sticky; set by a memory timeout.
- `illegal`  out  1  one-cycle pulse in DECODE for a reserved opcode.
- `instret`  out  16  count of retired instructions; wraps modulo 2^16.
- `state`  out  3  current FSM state, for debug.

## Operation
Opcode map (defined in the package):
- ALU ops: 6'h00–6'h1F.
- LD 6'h20, ST 6'h21.
- BEQ 6'h22 (taken if FLAG[0]=1), BNE 6'h23 (taken if FLAG[0]=0), JMP 6'h24 (always taken).
- Reserved: 6'h25–6'h3D, executed as NOP with `illegal` pulsed.
- NOP 6'h3E, HALT 6'h3F.

States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: load IR from `instructions`. Go to DECODE.
- DECODE: classify the IR.
  - NOP and reserved: assert `pc_en`, retire, go to FETCH.
  - HALT: go to HALT; no retire, no `pc_en`.
  - All others: go to EXEC.
- EXEC:
  - ALU op: `aluen`=1, go to WB.
  - LD/ST: `aluen`=1 for address generation, go to MEM.
  - Branch/JMP: `pc_en`=1, `branch`=1 if taken (FLAG sampled live in this cycle); retire; go to FETCH.
- MEM: LD holds `memread`=1 and ST holds `memwrite`=1 until `mem_ack` is sampled high.
  - LD with ack: go to WB.
  - ST with ack: `pc_en`=1 in the ack cycle, retire, go to FETCH.
  - Wait counter increments each MEM cycle without ack. On reaching `MEM_TIMEOUT`: set `halted` and `mem_err`, go to HALT.
  - Ack in the timeout cycle: the ack wins.
- WB: `regwrite`=1, `pc_en`=1, retire, go to FETCH.
- HALT: all strobes 0. Stays in HALT until `reset`.

General rules:
- Strobes are Moore outputs, decoded from state and IR only. The single exception is `branch`, which also uses `FLAG`.
- Never combinationally dependent on `mem_ack`, except `pc_en` in the ST ack cycle.
- At most one of `memread`/`memwrite` is high at any time.
- `pc_en` is high in exactly one cycle per retired instruction.

## Timing
- Reset values: state=FETCH; IR=0; all strobes 0; `halted`=0; `mem_err`=0; `illegal`=0; `instret`=0; wait counter=0.
- While `reset` is high, all strobes are forced to 0 regardless of state. Reset mid-instruction aborts it with no retire, and the next state is FETCH.
- Latency, cycles per instruction:
  - ALU: 4.
  - LD: 5 + W, where W = MEM cycles before ack.
  - ST: 4 + W.
  - Branch/JMP: 3.
  - NOP/reserved: 2.
  - Ack sampled in the first MEM cycle gives W=0.
- `instret` increments on the edge that ends the retiring cycle.
- The wait counter clears on every MEM entry.

## Structure
- Package `cpu_ctrl_pkg`: state enum, opcode constants, opcode-class function (alu/ld/st/br/nop/halt/reserved), FLAG bit indices.
- One sub-module, `cpu_decode`: combinational IR → class + branch-condition select. The FSM, counters and IR stay in the top.

## Test plan
- ALU op 6'h05 after reset → states 0,1,2,4,0; `aluen` in cycle 3, `regwrite`+`pc_en` in cycle 4; `instret`=1.
- LD with `mem_ack` delayed 3 cycles → `memread` held 4 cycles, WB follows, total 8 cycles; ST with immediate ack → `memwrite`+`pc_en` in the same cycle, total 4 cycles.
- BEQ with FLAG=8'h01 → `branch`=1, `pc_en`=1 in EXEC. BEQ with FLAG=8'h00 → `branch`=0, `pc_en`=1. BNE mirrors both cases.
- LD with `mem_ack` never asserted, MEM_TIMEOUT=15 → after 15 MEM cycles `halted`=`mem_err`=1 and strobes 0 thereafter. Repeat with ack in cycle 15 → completes normally.
- Opcode 6'h30 → `illegal` pulse in DECODE, `pc_en`=1, `instret`+1. Opcode 6'h3F → HALT, `instret` unchanged; `reset` pulse returns to FETCH with all counters 0.
- `reset` asserted in MEM during LD → strobes 0 that cycle, FETCH next, no retire.
